apb_router_to: RTL and testbench
================================

Name: apb_router_to

Overview:
- Parametrised next-generation APB router with one master port and SLV_C slave ports.
- Each slave has a programmable base/mask decode window.
- The router registers the forwarded transaction and drives its own slave-side setup/access phases.
- Unmapped addresses and hung slaves complete with an error (pslverr) instead of stalling the bus.
- It sits between the system APB bridge and the peripheral slaves.

Parameters:
SLV_C, 4, number of slave ports (1..16)
A_W, 16, address width
D_W, 32, data width
TO_W, 8, width of timeout counter and limit

Ports:
pclk  in  1  clock
preset  in  1  reset, asynchronous, active-high
paddr_base  in  SLV_C*A_W  per-slave base address, slave i at [i*A_W +: A_W]
paddr_msk  in  SLV_C*A_W  per-slave decode mask, same packing
pto_lim  in  TO_W  access-phase timeout limit in cycles; 0 disables timeout
paddr  in  A_W  master address
pwdata  in  D_W  master write data
psel  in  1  master select
pwrite  in  1  master write
penable  in  1  master enable
prdata  out  D_W  master read data
pready  out  1  master ready
pslverr  out  1  master error
paddr_s  out  A_W  registered address, common to all slaves
pwdata_s  out  D_W  registered write data, common to all slaves
pwrite_s  out  1  registered write, common to all slaves
psel_s  out  SLV_C  one-hot slave select
penable_s  out  1  slave enable, common to all slaves
prdata_s  in  SLV_C*D_W  slave read data, same packing as base/mask
pready_s  in  SLV_C  slave ready
pslverr_s  in  SLV_C  slave error

Behaviour:
- Reset (preset=1, async): all of the following go to 0 immediately:
  - outputs: prdata, pready, pslverr, paddr_s, pwdata_s, pwrite_s, psel_s, penable_s
  - internal state: FSM to IDLE, sel_idx, hit, timeout counter
- Decode: slave i hits when (paddr & msk_i) == (base_i & msk_i).
  - Multiple hits: lowest index wins.
  - No hit: miss.
  - Mask of all zeros hits every address.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - pready=0.
  - On psel=1 && penable=0 (master setup): latch paddr, pwdata, pwrite into paddr_s/pwdata_s/pwrite_s; latch sel_idx and hit.
  - Hit -> SETUP, with psel_s[sel_idx]=1, penable_s=0.
  - Miss -> RESP, with pslverr=1, prdata=0.
  - psel=1 with penable=1 while in IDLE (protocol error) is ignored.
- SETUP: one cycle; penable_s <= 1 -> ACCESS.
- ACCESS: psel_s and penable_s held; timeout counter increments each cycle, starting from 0 on entry.
  - pready_s[sel_idx]=1 -> register prdata <= prdata_s[sel_idx] and pslverr <= pslverr_s[sel_idx]; clear psel_s and penable_s; -> RESP.
  - Otherwise, if pto_lim!=0 and counter == pto_lim-1 -> clear psel_s and penable_s; prdata<=0, pslverr<=1; -> RESP.
  - pready_s and timeout in the same cycle: slave response wins.
  - pready_s of non-selected slaves is ignored.
- RESP:
  - pready=1 for exactly one cycle, with prdata/pslverr valid; -> IDLE.
  - prdata and pslverr hold their values until the next RESP; pslverr is not cleared early.
- Latency, counted from master setup cycle T0:
  - Hit with zero-wait slave: slave setup T1, slave access T2, master pready T3.
  - Slave with N wait cycles: pready at T3+N.
  - Miss: pready at T1.
  - Timeout with limit L: pready at T2+L.
- Master deasserting psel during SETUP/ACCESS (protocol violation) does not abort; the slave transaction completes and pready still pulses.
- Back-to-back: a new master setup presented in the cycle after RESP is accepted; no idle cycle is required beyond APB's own setup phase.
- pto_lim is sampled continuously; changing it mid-ACCESS takes effect on the next compare.
- prdata for a write transfer = registered prdata_s of the selected slave (don't-care to master); prdata=0 on miss or timeout.

Test Plan:
- SLV_C=4, bases 0x0000/0x1000/0x2000/0x3000, masks 0xF000; write 0x2004 data 0xA5A5_0001, slave2 zero-wait -> psel_s=4'b0100 at T1, penable_s at T2, paddr_s=0x2004, pwdata_s=0xA5A5_0001, pready at T3, pslverr=0.
- Read 0x1010, slave1 inserts 3 wait cycles and returns 0xDEAD_BEEF -> pready at T6, prdata=0xDEAD_BEEF, pslverr=0; other psel_s bits stay 0 throughout.
- Read 0x5000 (no hit) -> no psel_s bit ever asserted, pready at T1, pslverr=1, prdata=0.
- pto_lim=4, slave0 never ready on read of 0x0000 -> psel_s[0] high T1..T5, penable_s high T2..T5, both low at T6, pready at T6, pslverr=1; repeat with pto_lim=0 -> still waiting at T100.
- Overlapping windows: slave0 mask 0x0000, slave3 base 0x3000 mask 0xF000; access 0x3000 -> psel_s=4'b0001. Slave1 returns pslverr_s=1 -> master pslverr=1 at T3.
- Assert preset during ACCESS with psel_s=4'b0010 -> psel_s, penable_s, pready, pslverr go to 0 in the same cycle without waiting for a clock edge; after release, a new transfer to 0x1000 completes normally at T3.

Source files
------------

// File: rtl/apb_router_to_if.sv
// APB router bus bundle: upstream master-side signals plus the shared
// downstream slave-side signals. The router uses the slave modport; the
// environment (system bridge and peripherals) uses the master modport.
interface apb_router_to_if #(
  parameter int SLV_C = 4,
  parameter int A_W   = 16,
  parameter int D_W   = 32
);
  // upstream APB (router acts as a slave here)
  logic [A_W-1:0]       paddr;
  logic [D_W-1:0]       pwdata;
  logic                 psel;
  logic                 pwrite;
  logic                 penable;
  logic [D_W-1:0]       prdata;
  logic                 pready;
  logic                 pslverr;
  // downstream APB (router acts as a master here)
  logic [A_W-1:0]       paddr_s;
  logic [D_W-1:0]       pwdata_s;
  logic                 pwrite_s;
  logic [SLV_C-1:0]     psel_s;
  logic                 penable_s;
  logic [SLV_C*D_W-1:0] prdata_s;
  logic [SLV_C-1:0]     pready_s;
  logic [SLV_C-1:0]     pslverr_s;

  modport slave (
    input  paddr, pwdata, psel, pwrite, penable,
    input  prdata_s, pready_s, pslverr_s,
    output prdata, pready, pslverr,
    output paddr_s, pwdata_s, pwrite_s, psel_s, penable_s
  );

  modport master (
    output paddr, pwdata, psel, pwrite, penable,
    output prdata_s, pready_s, pslverr_s,
    input  prdata, pready, pslverr,
    input  paddr_s, pwdata_s, pwrite_s, psel_s, penable_s
  );
endinterface

// File: rtl/apb_router_to.sv
// APB router with per-slave base/mask decode windows. Each master transfer is
// registered and replayed on the slave side with its own setup/access phases.
// Unmapped addresses and slaves that stay busy past the timeout limit are
// completed with pslverr so the upstream bus never stalls.
module apb_router_to #(
  parameter int SLV_C = 4,
  parameter int A_W   = 16,
  parameter int D_W   = 32,
  parameter int TO_W  = 8
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic [SLV_C*A_W-1:0] paddr_base,
  input  logic [SLV_C*A_W-1:0] paddr_msk,
  input  logic [TO_W-1:0]      pto_lim,
  apb_router_to_if.slave       bus
);
  localparam int IDX_W = (SLV_C > 1) ? $clog2(SLV_C) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] dec_idx;
  logic             hit;
  logic             dec_hit;
  logic [TO_W-1:0]  to_cnt;
  logic             to_hit;
  logic [A_W-1:0]   paddr_r;
  logic [D_W-1:0]   pwdata_r;
  logic             pwrite_r;
  logic [SLV_C-1:0] psel_r;
  logic             penable_r;
  logic [D_W-1:0]   prdata_r;
  logic             pready_r;
  logic             pslverr_r;
  logic             sel_ready;
  logic             sel_err;
  logic [D_W-1:0]   sel_rdata;

  // Address decode; scanning downwards lets the lowest matching index win.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = SLV_C - 1; i >= 0; i--) begin
      if ((bus.paddr & paddr_msk[i*A_W +: A_W]) ==
          (paddr_base[i*A_W +: A_W] & paddr_msk[i*A_W +: A_W])) begin
        dec_hit = 1'b1;
        dec_idx = IDX_W'(i);
      end
    end
  end

  // Response mux of the latched slave; other slaves' ready lines are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < SLV_C; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_ready = hit & bus.pready_s[i];
        sel_err   = bus.pslverr_s[i];
        sel_rdata = bus.prdata_s[i*D_W +: D_W];
      end
    end
  end

  // Limit is read live, so a change during ACCESS applies at the next compare.
  assign to_hit = (pto_lim != '0) && (to_cnt == pto_lim - TO_W'(1));

  // Transfer FSM with all bus outputs registered.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= IDLE;
      sel_idx   <= '0;
      hit       <= 1'b0;
      to_cnt    <= '0;
      paddr_r   <= '0;
      pwdata_r  <= '0;
      pwrite_r  <= 1'b0;
      psel_r    <= '0;
      penable_r <= 1'b0;
      prdata_r  <= '0;
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
    end else begin
      pready_r <= 1'b0;
      unique case (state)
        IDLE: begin
          // psel with penable already high is a protocol error and is ignored
          if (bus.psel && !bus.penable) begin
            paddr_r  <= bus.paddr;
            pwdata_r <= bus.pwdata;
            pwrite_r <= bus.pwrite;
            sel_idx  <= dec_idx;
            hit      <= dec_hit;
            to_cnt   <= '0;
            if (dec_hit) begin
              psel_r <= SLV_C'(1) << dec_idx;
              state  <= SETUP;
            end else begin
              prdata_r  <= '0;
              pslverr_r <= 1'b1;
              pready_r  <= 1'b1;
              state     <= RESP;
            end
          end
        end
        SETUP: begin
          penable_r <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          // slave response takes priority over a coincident timeout
          if (sel_ready) begin
            prdata_r  <= sel_rdata;
            pslverr_r <= sel_err;
            psel_r    <= '0;
            penable_r <= 1'b0;
            pready_r  <= 1'b1;
            state     <= RESP;
          end else if (to_hit) begin
            prdata_r  <= '0;
            pslverr_r <= 1'b1;
            psel_r    <= '0;
            penable_r <= 1'b0;
            pready_r  <= 1'b1;
            state     <= RESP;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.paddr_s   = paddr_r;
  assign bus.pwdata_s  = pwdata_r;
  assign bus.pwrite_s  = pwrite_r;
  assign bus.psel_s    = psel_r;
  assign bus.penable_s = penable_r;
  assign bus.prdata    = prdata_r;
  assign bus.pready    = pready_r;
  assign bus.pslverr   = pslverr_r;
endmodule

// File: tb/tb_apb_router_to.sv
// Bench for apb_router_to: directed vector table, hand-written multi-cycle
// sequences (timeout waveform, hung slave + async reset, overlap, protocol
// corner cases) and randomized transfers against a decode/latency model.
module tb_apb_router_to;
  logic        pclk = 1'b0;
  logic        preset;
  logic [15:0] bs  [4];
  logic [15:0] msk [4];
  logic [63:0] base_flat;
  logic [63:0] msk_flat;
  logic [7:0]  lim;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] ps_h [0:127];
  logic       pe_h [0:127];

  apb_router_to_if #(.SLV_C(4), .A_W(16), .D_W(32)) bus ();

  apb_router_to #(.SLV_C(4), .A_W(16), .D_W(32), .TO_W(8)) dut (
    .pclk       (pclk),
    .preset     (preset),
    .paddr_base (base_flat),
    .paddr_msk  (msk_flat),
    .pto_lim    (lim),
    .bus        (bus.slave)
  );

  assign base_flat = {bs[3], bs[2], bs[1], bs[0]};
  assign msk_flat  = {msk[3], msk[2], msk[1], msk[0]};

  always #5 pclk = ~pclk;

  typedef struct {
    logic [7:0]  lim;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        wr;
    int          waits;
    logic [31:0] rd_s;
    logic        er_s;
    int          exp_lat;
    logic [3:0]  exp_ps;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Master + slave emulation for one transfer. waits<0 means the slave never
  // answers. Non-selected slaves toggle random ready/error noise.
  task automatic do_xfer(input logic [15:0] a, input logic [31:0] wd, input logic wr,
                         input int waits, input logic [31:0] rd_s, input logic er_s,
                         input bit drop, input int budget,
                         output int lat, output logic [31:0] rd, output logic er,
                         output logic [3:0] ps_or);
    int acc;
    bit done;
    logic [3:0] noise;
    @(negedge pclk);
    bus.paddr = a; bus.pwdata = wd; bus.pwrite = wr;
    bus.psel = 1'b1; bus.penable = 1'b0;
    bus.pready_s = '0; bus.pslverr_s = '0;
    lat = -1; rd = '0; er = 1'b0; ps_or = '0; acc = 0; done = 0;
    for (int k = 1; k <= budget && !done; k++) begin
      @(negedge pclk);
      ps_h[k] = bus.psel_s;
      pe_h[k] = bus.penable_s;
      ps_or   = ps_or | bus.psel_s;
      if (drop) begin bus.psel = 1'b0; bus.penable = 1'b0; end
      else bus.penable = 1'b1;
      if (bus.pready) begin
        lat = k; rd = bus.prdata; er = bus.pslverr; done = 1;
        bus.psel = 1'b0; bus.penable = 1'b0;
      end
      if (bus.penable_s && bus.psel_s != 4'b0) acc++;
      noise = 4'($urandom);
      bus.prdata_s = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 4; i++) if (bus.psel_s[i]) bus.prdata_s[i*32 +: 32] = rd_s;
      bus.pslverr_s = (4'($urandom) & ~bus.psel_s) | (er_s ? bus.psel_s : 4'b0);
      if (waits >= 0 && acc > waits) bus.pready_s = bus.psel_s | (noise & ~bus.psel_s);
      else bus.pready_s = noise & ~bus.psel_s;
    end
    bus.pready_s = '0;
  endtask

  // Reference: window decode (lowest index wins), then latency/result from
  // the wait count versus the timeout limit.
  task automatic model(input logic [15:0] a, input int waits, input logic [31:0] rd_s,
                       input logic er_s, output int lat, output logic [31:0] rd,
                       output logic er, output logic [3:0] ps);
    int idx = -1;
    for (int i = 3; i >= 0; i--) if ((a & msk[i]) == (bs[i] & msk[i])) idx = i;
    if (idx < 0) begin
      lat = 1; rd = '0; er = 1'b1; ps = '0;
    end else begin
      ps = 4'(1 << idx);
      if (lim != 0 && (waits < 0 || waits >= int'(lim))) begin
        lat = 2 + int'(lim); rd = '0; er = 1'b1;
      end else begin
        lat = 3 + waits; rd = rd_s; er = er_s;
      end
    end
  endtask

  task automatic default_map();
    for (int i = 0; i < 4; i++) begin
      bs[i]  = 16'(i << 12);
      msk[i] = 16'hF000;
    end
  endtask

  vec_t vt [8];

  initial begin
    int lat, elat;
    logic [31:0] rd, erd;
    logic er, eer;
    logic [3:0] ps, eps;

    vt[0] = '{8'd0, 16'h2004, 32'hA5A5_0001, 1'b1, 0,  32'h1111_1111, 1'b0, 3, 4'b0100, 32'h1111_1111, 1'b0};
    vt[1] = '{8'd0, 16'h1010, 32'h0,         1'b0, 3,  32'hDEAD_BEEF, 1'b0, 6, 4'b0010, 32'hDEAD_BEEF, 1'b0};
    vt[2] = '{8'd0, 16'h5000, 32'h0,         1'b0, 0,  32'h1234_5678, 1'b0, 1, 4'b0000, 32'h0,         1'b1};
    vt[3] = '{8'd4, 16'h0000, 32'h0,         1'b0, -1, 32'h7777_7777, 1'b0, 6, 4'b0001, 32'h0,         1'b1};
    vt[4] = '{8'd0, 16'h1000, 32'h0,         1'b0, 0,  32'hCAFE_0000, 1'b1, 3, 4'b0010, 32'hCAFE_0000, 1'b1};
    vt[5] = '{8'd3, 16'h3008, 32'h0,         1'b0, 2,  32'h0BAD_F00D, 1'b0, 5, 4'b1000, 32'h0BAD_F00D, 1'b0};
    vt[6] = '{8'd3, 16'h3008, 32'h0,         1'b0, 3,  32'h0BAD_F00D, 1'b0, 5, 4'b1000, 32'h0,         1'b1};
    vt[7] = '{8'd1, 16'h2000, 32'h55AA_0000, 1'b1, 0,  32'h55AA_55AA, 1'b0, 3, 4'b0100, 32'h55AA_55AA, 1'b0};

    default_map();
    lim = 8'd0;
    preset = 1'b1;
    bus.paddr = '0; bus.pwdata = '0; bus.pwrite = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
    bus.prdata_s = '0; bus.pready_s = '0; bus.pslverr_s = '0;
    repeat (2) @(negedge pclk);
    chk("rst_psel_s", 64'(bus.psel_s), 64'h0);
    chk("rst_penable_s", 64'(bus.penable_s), 64'h0);
    chk("rst_pready", 64'(bus.pready), 64'h0);
    chk("rst_pslverr", 64'(bus.pslverr), 64'h0);
    chk("rst_prdata", 64'(bus.prdata), 64'h0);
    chk("rst_paddr_s", 64'(bus.paddr_s), 64'h0);
    preset = 1'b0;

    // directed table
    for (int t = 0; t < 8; t++) begin
      lim = vt[t].lim;
      do_xfer(vt[t].addr, vt[t].wdata, vt[t].wr, vt[t].waits, vt[t].rd_s, vt[t].er_s, 0, 40,
              lat, rd, er, ps);
      chk($sformatf("vec%0d_lat", t), 64'(lat), 64'(vt[t].exp_lat));
      chk($sformatf("vec%0d_psel", t), 64'(ps), 64'(vt[t].exp_ps));
      chk($sformatf("vec%0d_prdata", t), 64'(rd), 64'(vt[t].exp_rd));
      chk($sformatf("vec%0d_pslverr", t), 64'(er), 64'(vt[t].exp_er));
      chk($sformatf("vec%0d_paddr_s", t), 64'(bus.paddr_s), 64'(vt[t].addr));
      chk($sformatf("vec%0d_pwdata_s", t), 64'(bus.pwdata_s), 64'(vt[t].wdata));
      chk($sformatf("vec%0d_pwrite_s", t), 64'(bus.pwrite_s), 64'(vt[t].wr));
    end

    // timeout waveform, limit 4, slave0 never ready
    lim = 8'd4;
    do_xfer(16'h0000, 32'h0, 1'b0, -1, 32'h0, 1'b0, 0, 40, lat, rd, er, ps);
    chk("to_lat", 64'(lat), 64'd6);
    for (int k = 1; k <= 5; k++) chk($sformatf("to_psel_T%0d", k), 64'(ps_h[k]), 64'h1);
    chk("to_penable_T1", 64'(pe_h[1]), 64'h0);
    for (int k = 2; k <= 5; k++) chk($sformatf("to_penable_T%0d", k), 64'(pe_h[k]), 64'h1);
    chk("to_psel_T6", 64'(ps_h[6]), 64'h0);
    chk("to_penable_T6", 64'(pe_h[6]), 64'h0);

    // pslverr/prdata hold after a miss until the next response
    lim = 8'd0;
    do_xfer(16'h5000, 32'h0, 1'b0, 0, 32'h0, 1'b0, 0, 40, lat, rd, er, ps);
    chk("miss_lat", 64'(lat), 64'd1);
    repeat (2) begin
      @(negedge pclk);
      chk("hold_pslverr", 64'(bus.pslverr), 64'h1);
      chk("hold_pready", 64'(bus.pready), 64'h0);
    end

    // psel+penable while idle is ignored
    @(negedge pclk);
    bus.paddr = 16'h1000; bus.psel = 1'b1; bus.penable = 1'b1;
    repeat (2) begin
      @(negedge pclk);
      chk("proto_psel_s", 64'(bus.psel_s), 64'h0);
      chk("proto_pready", 64'(bus.pready), 64'h0);
    end
    bus.psel = 1'b0; bus.penable = 1'b0;

    // master drops psel after setup: transfer still completes
    do_xfer(16'h2010, 32'h0, 1'b0, 1, 32'h600D_0001, 1'b0, 1, 40, lat, rd, er, ps);
    chk("drop_lat", 64'(lat), 64'd4);
    chk("drop_prdata", 64'(rd), 64'h600D_0001);

    // overlapping windows: mask-0 slave0 catches everything
    msk[0] = 16'h0000;
    do_xfer(16'h3000, 32'h0, 1'b0, 0, 32'h0000_0AAA, 1'b0, 0, 40, lat, rd, er, ps);
    chk("ovl_psel", 64'(ps), 64'h1);
    chk("ovl_lat", 64'(lat), 64'd3);
    default_map();

    // hung slave1 with timeout disabled, then async reset mid-access
    lim = 8'd0;
    do_xfer(16'h1000, 32'h0, 1'b0, -1, 32'h0, 1'b0, 0, 100, lat, rd, er, ps);
    chk("hung_no_pready", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("hung_psel_T100", 64'(ps_h[100]), 64'h2);
    chk("hung_penable_T100", 64'(pe_h[100]), 64'h1);
    bus.psel = 1'b0; bus.penable = 1'b0;
    #2 preset = 1'b1;
    #1;
    chk("arst_psel_s", 64'(bus.psel_s), 64'h0);
    chk("arst_penable_s", 64'(bus.penable_s), 64'h0);
    chk("arst_pready", 64'(bus.pready), 64'h0);
    chk("arst_pslverr", 64'(bus.pslverr), 64'h0);
    @(negedge pclk);
    preset = 1'b0;
    do_xfer(16'h1000, 32'h0, 1'b0, 0, 32'h0000_1234, 1'b0, 0, 40, lat, rd, er, ps);
    chk("post_rst_lat", 64'(lat), 64'd3);
    chk("post_rst_psel", 64'(ps), 64'h2);
    chk("post_rst_prdata", 64'(rd), 64'h0000_1234);

    // randomized back-to-back transfers against the model
    for (int n = 0; n < 60; n++) begin
      int w;
      logic [15:0] a;
      logic [31:0] rs;
      logic es, wr;
      bit dr;
      for (int i = 0; i < 4; i++) begin
        bs[i] = {4'($urandom_range(0, 7)), 12'($urandom)};
        case ($urandom_range(0, 7))
          0:       msk[i] = 16'h0000;
          1, 2:    msk[i] = 16'hF800;
          default: msk[i] = 16'hF000;
        endcase
      end
      lim = 8'($urandom_range(0, 6));
      w   = $urandom_range(0, 5);
      if (lim != 0 && $urandom_range(0, 3) == 0) w = -1;
      a  = 16'($urandom_range(0, 16'h7FFF));
      rs = $urandom;
      es = 1'($urandom);
      wr = 1'($urandom);
      dr = ($urandom_range(0, 7) == 0);
      model(a, w, rs, es, elat, erd, eer, eps);
      do_xfer(a, 32'($urandom), wr, w, rs, es, dr, 40, lat, rd, er, ps);
      chk($sformatf("rnd%0d_lat", n), 64'(lat), 64'(elat));
      chk($sformatf("rnd%0d_psel", n), 64'(ps), 64'(eps));
      chk($sformatf("rnd%0d_prdata", n), 64'(rd), 64'(erd));
      chk($sformatf("rnd%0d_pslverr", n), 64'(er), 64'(eer));
      chk($sformatf("rnd%0d_paddr_s", n), 64'(bus.paddr_s), 64'(a));
      chk($sformatf("rnd%0d_pwrite_s", n), 64'(bus.pwrite_s), 64'(wr));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
